arith_unit: RTL and testbench

Parametrised successor to the 4-bit add/multiply block. It adds subtract and multiply-accumulate (MAC), an in_valid/in_ready/out_valid handshake and an iterative shift-add multiplier. The opcode is held in a register loaded by newop, so a host can issue a stream of operands under one operator. The block sits between the operand-entry logic and the display/result path.

---
 rtl/arith_pkg.sv | 16 +
 rtl/arith_seq_mult.sv | 54 +++++
 rtl/arith_unit.sv | 131 +++++++++++++
 tb/tb_arith_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared operator and FSM encodings for the arithmetic unit.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/arith_seq_mult.sv
// Iterative shift-add multiplier: one partial-product step per clock for WIDTH clocks.
// done and product are combinational on the final step so the caller can register the result on that edge.
module arith_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt;
    logic               running;

    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        product = partial + addend;
        done    = running && (cnt == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= (2*WIDTH)'(a);
            mplier  <= b;
            partial <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            partial <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arith_unit.sv
// ADD/SUB (latency 1) and MUL/MAC (latency WIDTH+1, in_ready low while multiplying) with a sticky operator register.
// Optional saturation of ADD/MAC overflow and SUB underflow under macro ARITH_SAT_EN.
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ANS_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     V1,
    input  logic [WIDTH-1:0]     V2,
    input  logic [1:0]           opcode,
    input  logic                 newop,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ANS_WIDTH-1:0] ans,
    output logic                 out_valid,
    output logic                 busy
);
    generate
        if (ANS_WIDTH < 2*WIDTH || WIDTH < 2) begin : g_bad_params
            $error("arith_unit: need WIDTH >= 2 and ANS_WIDTH >= 2*WIDTH");
        end
    endgenerate

    op_e                 oper;
    op_e                 eff_op;
    logic                mac_q;
    state_e              state;
    state_e              state_next;
    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  product;
    logic signed [WIDTH:0] sub_diff;
    logic [ANS_WIDTH-1:0] add_res;
    logic [ANS_WIDTH-1:0] sub_res;
    logic [ANS_WIDTH-1:0] mul_res;
    logic [ANS_WIDTH-1:0] mac_res;
`ifdef ARITH_SAT_EN
    logic [ANS_WIDTH:0]   add_wide;
    logic [ANS_WIDTH:0]   mac_wide;
`endif

    assign in_ready = (state == S_IDLE);
    assign busy     = ~in_ready;

    // A newop in the accept cycle overrides the stored operator for that operation.
    always_comb begin
        eff_op    = newop ? op_e'(opcode) : oper;
        accept    = in_valid && in_ready;
        mul_start = accept && (eff_op == OP_MUL || eff_op == OP_MAC);
    end

    always_comb begin
        sub_diff = $signed({1'b0, V1}) - $signed({1'b0, V2});
        mul_res  = ANS_WIDTH'(product);
`ifdef ARITH_SAT_EN
        add_wide = (ANS_WIDTH+1)'(V1) + (ANS_WIDTH+1)'(V2);
        add_res  = add_wide[ANS_WIDTH] ? '1 : add_wide[ANS_WIDTH-1:0];
        mac_wide = (ANS_WIDTH+1)'(ans) + (ANS_WIDTH+1)'(product);
        mac_res  = mac_wide[ANS_WIDTH] ? '1 : mac_wide[ANS_WIDTH-1:0];
        sub_res  = sub_diff[WIDTH] ? '0 : ANS_WIDTH'(sub_diff);
`else
        add_res  = ANS_WIDTH'(V1) + ANS_WIDTH'(V2);
        mac_res  = ans + ANS_WIDTH'(product);
        sub_res  = ANS_WIDTH'(sub_diff);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mul_start) state_next = S_MUL;
            S_MUL:   if (mul_done)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ans is untouched while multiplying, so at completion it still holds the value seen at accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oper      <= OP_ADD;
            mac_q     <= 1'b0;
            ans       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (newop) begin
                oper <= op_e'(opcode);
            end
            if (accept) begin
                case (eff_op)
                    OP_ADD: begin
                        ans       <= add_res;
                        out_valid <= 1'b1;
                    end
                    OP_SUB: begin
                        ans       <= sub_res;
                        out_valid <= 1'b1;
                    end
                    default: mac_q <= (eff_op == OP_MAC);
                endcase
            end
            if (mul_done) begin
                ans       <= mac_q ? mac_res : mul_res;
                out_valid <= 1'b1;
            end
        end
    end

    arith_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (V1),
        .b       (V2),
        .done    (mul_done),
        .product (product)
    );

endmodule

// File: tb/tb_arith_unit.sv
// Directed bench for arith_unit at WIDTH=4 and WIDTH=8 with per-instance expected-result queues.
module tb_arith_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  v1, v2;
    logic [1:0]  opcode;
    logic        newop, in_valid;
    logic        in_ready, out_valid, busy;
    logic [15:0] ans;

    logic [7:0]  v1_8, v2_8;
    logic [1:0]  opcode8;
    logic        newop8, in_valid8;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] ans8;

    logic [15:0] exp_q[$];
    logic [15:0] exp8_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    arith_unit #(.WIDTH(4), .ANS_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .V1(v1), .V2(v2), .opcode(opcode),
        .newop(newop), .in_valid(in_valid), .in_ready(in_ready),
        .ans(ans), .out_valid(out_valid), .busy(busy)
    );

    arith_unit #(.WIDTH(8), .ANS_WIDTH(16)) dut8 (
        .clock(clock), .reset(reset), .V1(v1_8), .V2(v2_8), .opcode(opcode8),
        .newop(newop8), .in_valid(in_valid8), .in_ready(in_ready8),
        .ans(ans8), .out_valid(out_valid8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboards: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (out_valid) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb4_spurious: observed out_valid with ans %0h expected no pulse", ans);
            end
            if (exp_q.size() != 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                n_vec++;
                assert (ans === e) else begin
                    n_err++;
                    $error("FAIL sb4_ans: observed %0h expected %0h", ans, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (out_valid8) begin
            n_vec++;
            assert (exp8_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb8_spurious: observed out_valid with ans %0h expected no pulse", ans8);
            end
            if (exp8_q.size() != 0) begin
                logic [15:0] e;
                e = exp8_q.pop_front();
                n_vec++;
                assert (ans8 === e) else begin
                    n_err++;
                    $error("FAIL sb8_ans: observed %0h expected %0h", ans8, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b1;
        v1 = '0; v2 = '0; opcode = 2'b00; newop = 1'b0; in_valid = 1'b0;
        v1_8 = '0; v2_8 = '0; opcode8 = 2'b00; newop8 = 1'b0; in_valid8 = 1'b0;

        // 1: power-up reset, idle reset, default ADD
        repeat (2) @(negedge clock);
        check("rst_ans", ans, 16'd0);
        check("rst_ov", out_valid, 1'b0);
        check("rst_rdy", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        v1 = 4'd9; v2 = 4'd7; in_valid = 1'b1; exp_q.push_back(16'd16);
        @(negedge clock);
        in_valid = 1'b0;
        check("add_ov", out_valid, 1'b1);
        check("add_ans", ans, 16'd16);
        reset = 1'b1;
        @(negedge clock);
        check("idle_rst_ans", ans, 16'd0);
        reset = 1'b0;
        @(negedge clock);
        v1 = 4'd15; v2 = 4'd15; in_valid = 1'b1; exp_q.push_back(16'd30);
        @(negedge clock);
        in_valid = 1'b0;
        check("add_max", ans, 16'd30);

        // 2: MUL 15*15 with ignored in_valid during busy
        newop = 1'b1; opcode = 2'b01; in_valid = 1'b1; exp_q.push_back(16'd225);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            newop = 1'b0;
            v1 = 4'd1; v2 = 4'd1;
            in_valid = (k < 4);
            if (k < 5) begin
                check($sformatf("mul_rdy_%0d", k), in_ready, 1'b0);
                check($sformatf("mul_busy_%0d", k), busy, 1'b1);
                check($sformatf("mul_noov_%0d", k), out_valid, 1'b0);
            end else begin
                check("mul_ov", out_valid, 1'b1);
                check("mul_ans", ans, 16'd225);
                check("mul_rdy_back", in_ready, 1'b1);
            end
        end
        @(negedge clock);
        check("mul_single_pulse", out_valid, 1'b0);

        // 3: SUB underflow, zero and positive
        newop = 1'b1; opcode = 2'b10; v1 = 4'd3; v2 = 4'd9; in_valid = 1'b1;
`ifdef ARITH_SAT_EN
        exp_q.push_back(16'd0);
`else
        exp_q.push_back(16'hFFFA);
`endif
        @(negedge clock);
        newop = 1'b0;
`ifdef ARITH_SAT_EN
        check("sub_neg", ans, 16'd0);
`else
        check("sub_neg", ans, 16'hFFFA);
`endif
        v1 = 4'd9; v2 = 4'd3; exp_q.push_back(16'd6);
        @(negedge clock);
        check("sub_pos", ans, 16'd6);
        v1 = 4'd5; v2 = 4'd5; exp_q.push_back(16'd0);
        @(negedge clock);
        in_valid = 1'b0;
        check("sub_zero", ans, 16'd0);

        // 5: reset during the second multiply step
        newop = 1'b1; opcode = 2'b01; v1 = 4'd15; v2 = 4'd15; in_valid = 1'b1;
        @(negedge clock);
        newop = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_ans", ans, 16'd0);
        check("abort_rdy", in_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        check("abort_noov", out_valid, 1'b0);
        v1 = 4'd1; v2 = 4'd1; in_valid = 1'b1; exp_q.push_back(16'd2);
        @(negedge clock);
        in_valid = 1'b0;
        check("abort_add", ans, 16'd2);

        // 6: newop during busy does not disturb the running MUL
        newop = 1'b1; opcode = 2'b01; v1 = 4'd13; v2 = 4'd11; in_valid = 1'b1;
        exp_q.push_back(16'd143);
        @(negedge clock);
        in_valid = 1'b0; newop = 1'b1; opcode = 2'b00;
        @(negedge clock);
        newop = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("mulnewop_done", seen, 1'b1);
        check("mulnewop_ans", ans, 16'd143);
        v1 = 4'd5; v2 = 4'd6; in_valid = 1'b1; exp_q.push_back(16'd11);
        @(negedge clock);
        in_valid = 1'b0;
        check("after_newop_add", ans, 16'd11);

        // 4: WIDTH=8 MAC wrap / saturate
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("w8_rst_ans", ans8, 16'd0);
        newop8 = 1'b1; opcode8 = 2'b11; v1_8 = 8'd255; v2_8 = 8'd255; in_valid8 = 1'b1;
        exp8_q.push_back(16'd65025);
        @(negedge clock);
        newop8 = 1'b0; in_valid8 = 1'b0;
        check("w8_busy", in_ready8, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (out_valid8) seen = 1'b1;
        end
        check("mac1_done", seen, 1'b1);
        check("mac1_ans", ans8, 16'd65025);
        in_valid8 = 1'b1;
`ifdef ARITH_SAT_EN
        exp8_q.push_back(16'hFFFF);
`else
        exp8_q.push_back(16'd64514);
`endif
        @(negedge clock);
        in_valid8 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (out_valid8) seen = 1'b1;
        end
        check("mac2_done", seen, 1'b1);
`ifdef ARITH_SAT_EN
        check("mac2_ans", ans8, 16'hFFFF);
`else
        check("mac2_ans", ans8, 16'd64514);
`endif

        repeat (3) @(negedge clock);
        check("sb4_drained", exp_q.size(), 0);
        check("sb8_drained", exp8_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
